// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcodes, ALU op encodings, instruction field positions
// and the main-control decoder used by the decode stage.
package mips_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned REG_COUNT  = 32;
  localparam int unsigned REG_ADDR_W = 5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned RS_MSB     = 25;
  localparam int unsigned RS_LSB     = 21;
  localparam int unsigned RT_MSB     = 20;
  localparam int unsigned RT_LSB     = 16;
  localparam int unsigned RD_MSB     = 15;
  localparam int unsigned RD_LSB     = 11;
  localparam int unsigned IMM_MSB    = 15;
  localparam int unsigned IMM_LSB    = 0;
  localparam int unsigned FUNCT_MSB  = 5;
  localparam int unsigned FUNCT_LSB  = 0;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       reg_dst;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_t;

  // Unknown opcodes decode to an all-zero bubble.
  function automatic ctrl_t decode_ctrl(input logic [5:0] opcode);
    ctrl_t c;
    c = '0;
    case (opcode)
      OP_RTYPE: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
        c.alu_op    = ALUOP_FUNCT;
      end
      OP_LW: begin
        c.reg_write  = 1'b1;
        c.mem_read   = 1'b1;
        c.mem_to_reg = 1'b1;
        c.alu_src    = 1'b1;
        c.alu_op     = ALUOP_ADD;
      end
      OP_SW: begin
        c.mem_write = 1'b1;
        c.alu_src   = 1'b1;
        c.alu_op    = ALUOP_ADD;
      end
      OP_BEQ: begin
        c.branch = 1'b1;
        c.alu_op = ALUOP_SUB;
      end
      OP_ADDI: begin
        c.reg_write = 1'b1;
        c.alu_src   = 1'b1;
        c.alu_op    = ALUOP_ADD;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic uses_rt(input logic [5:0] opcode);
    return (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);
  endfunction

endpackage

// File: rtl/register_file.sv
// 32x32 register file: two read ports, one write port, r0 hardwired to zero and
// same-cycle write-to-read bypass.
module register_file
  import mips_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REG_COUNT  = 32,
  parameter int unsigned ADDR_W     = $clog2(REG_COUNT)
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [ADDR_W-1:0]     rs_addr,
  input  logic [ADDR_W-1:0]     rt_addr,
  output logic [DATA_WIDTH-1:0] rs_data,
  output logic [DATA_WIDTH-1:0] rt_data,
  input  logic                  wb_en,
  input  logic [ADDR_W-1:0]     wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data
);

  logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
  logic                  wr_valid;

  assign wr_valid = wb_en && (wb_addr != '0);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < int'(REG_COUNT); i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_valid) begin
      regs_q[wb_addr] <= wb_data;
    end
  end

  always_comb begin
    rs_data = regs_q[rs_addr];
    rt_data = regs_q[rt_addr];
    if (rs_addr == '0)                          rs_data = '0;
    else if (wr_valid && (wb_addr == rs_addr))  rs_data = wb_data;
    if (rt_addr == '0)                          rt_data = '0;
    else if (wr_valid && (wb_addr == rt_addr))  rt_data = wb_data;
  end

endmodule

// File: rtl/instruction_decode_stage.sv
// MIPS ID stage: field/control decode, register read, load-use hazard detection and
// the ID/EX pipeline register.
module instruction_decode_stage
  import mips_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REG_COUNT  = 32
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [31:0]           IR,
  input  logic [31:0]           PC_plus4,
  input  logic                  wb_en,
  input  logic [4:0]            wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  pc_write_enable,
  output logic                  ifid_write_enable,
  output logic [DATA_WIDTH-1:0] ex_rs_data,
  output logic [DATA_WIDTH-1:0] ex_rt_data,
  output logic [DATA_WIDTH-1:0] ex_imm,
  output logic [4:0]            ex_rs,
  output logic [4:0]            ex_rt,
  output logic [4:0]            ex_rd,
  output logic [5:0]            ex_funct,
  output logic [31:0]           ex_pc_plus4,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_mem_to_reg,
  output logic                  ex_alu_src,
  output logic                  ex_reg_dst,
  output logic                  ex_branch,
  output logic [1:0]            ex_alu_op
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] rs_data;
    logic [DATA_WIDTH-1:0] rt_data;
    logic [DATA_WIDTH-1:0] imm;
    logic [4:0]            rs;
    logic [4:0]            rt;
    logic [4:0]            rd;
    logic [5:0]            funct;
    logic [31:0]           pc_plus4;
    ctrl_t                 ctrl;
  } idex_t;

  idex_t                 idex_d, idex_q;
  logic [5:0]            opcode;
  logic [4:0]            id_rs, id_rt, id_rd;
  logic [DATA_WIDTH-1:0] rs_data, rt_data;
  logic                  hazard;

  assign opcode = IR[OPCODE_MSB:OPCODE_LSB];
  assign id_rs  = IR[RS_MSB:RS_LSB];
  assign id_rt  = IR[RT_MSB:RT_LSB];
  assign id_rd  = IR[RD_MSB:RD_LSB];

  register_file #(
    .DATA_WIDTH (DATA_WIDTH),
    .REG_COUNT  (REG_COUNT),
    .ADDR_W     (5)
  ) u_register_file (
    .CLK     (CLK),
    .RESET   (RESET),
    .rs_addr (id_rs),
    .rt_addr (id_rt),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .wb_data (wb_data)
  );

  // Load in EX whose destination feeds this instruction: hold IF/ID and PC, send a bubble.
  assign hazard = idex_q.ctrl.mem_read && (idex_q.rt != '0) &&
                  ((idex_q.rt == id_rs) || (uses_rt(opcode) && (idex_q.rt == id_rt)));

  assign pc_write_enable   = !hazard;
  assign ifid_write_enable = !hazard;

  always_comb begin
    idex_d = '0;
    if (!hazard) begin
      idex_d.rs_data  = rs_data;
      idex_d.rt_data  = rt_data;
      idex_d.imm      = {{(DATA_WIDTH-16){IR[IMM_MSB]}}, IR[IMM_MSB:IMM_LSB]};
      idex_d.rs       = id_rs;
      idex_d.rt       = id_rt;
      idex_d.rd       = id_rd;
      idex_d.funct    = IR[FUNCT_MSB:FUNCT_LSB];
      idex_d.pc_plus4 = PC_plus4;
      idex_d.ctrl     = decode_ctrl(opcode);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) idex_q <= '0;
    else       idex_q <= idex_d;
  end

  assign ex_rs_data    = idex_q.rs_data;
  assign ex_rt_data    = idex_q.rt_data;
  assign ex_imm        = idex_q.imm;
  assign ex_rs         = idex_q.rs;
  assign ex_rt         = idex_q.rt;
  assign ex_rd         = idex_q.rd;
  assign ex_funct      = idex_q.funct;
  assign ex_pc_plus4   = idex_q.pc_plus4;
  assign ex_reg_write  = idex_q.ctrl.reg_write;
  assign ex_mem_read   = idex_q.ctrl.mem_read;
  assign ex_mem_write  = idex_q.ctrl.mem_write;
  assign ex_mem_to_reg = idex_q.ctrl.mem_to_reg;
  assign ex_alu_src    = idex_q.ctrl.alu_src;
  assign ex_reg_dst    = idex_q.ctrl.reg_dst;
  assign ex_branch     = idex_q.ctrl.branch;
  assign ex_alu_op     = idex_q.ctrl.alu_op;

endmodule
